fnv1a_hash_ctrl: RTL and testbench

Sequencer for the 32-bit FNV-1a hashing datapath behind the I2C target. It accepts byte and control commands from the I2C register front-end over a valid/ready handshake. Each byte is XOR-folded into the running hash, then multiplied by the FNV prime using a multi-cycle shift-add schedule, so no 32×32 multiplier is needed. On command it snapshots the hash into a digest register that the I2C read path samples one byte at a time.

---
 rtl/fnv1a_pkg.sv | 33 +++
 rtl/fnv1a_hash_ctrl.sv | 84 ++++++++
 tb/tb_fnv1a_hash_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fnv1a_pkg.sv
// Shared constants, opcode/state encodings and the FNV-1a shift-add schedule.
package fnv1a_pkg;

  localparam logic [31:0] FNV_OFFSET_BASIS = 32'h811C9DC5;
  localparam logic [31:0] FNV_PRIME        = 32'h01000193;

  typedef enum logic [1:0] {
    OP_BYTE  = 2'b00,
    OP_INIT  = 2'b01,
    OP_LATCH = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  localparam int unsigned MUL_STEPS = 5;

  // FNV prime = 2^24 + 2^8 + 2^7 + 2^4 + 2^1 + 2^0; the 2^0 term is the XOR-fold itself.
  localparam logic [MUL_STEPS-1:0][4:0] SHIFT_TABLE = {5'd24, 5'd8, 5'd7, 5'd4, 5'd1};

  function automatic logic [4:0] shift_of(input logic [2:0] step);
    logic [4:0] amt;
    amt = '0;
    for (int unsigned i = 0; i < MUL_STEPS; i++) begin
      if (step == 3'(i)) amt = SHIFT_TABLE[i];
    end
    return amt;
  endfunction

endpackage

// File: rtl/fnv1a_hash_ctrl.sv
// FNV-1a 32-bit hash sequencer: byte/control command handshake, shift-add multiply, digest latch.
module fnv1a_hash_ctrl
  import fnv1a_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [7:0]         cmd_data,
  input  logic [1:0]         rd_idx,
  output logic [7:0]         rd_data,
  output logic               digest_valid,
  output logic               busy,
  output logic [COUNT_W-1:0] byte_count
);

  state_e      state;
  logic [2:0]  step;
  logic [31:0] hash;
  logic [31:0] xr;
  logic [31:0] digest;
  logic [31:0] folded;
  logic [31:0] mul_sum;
  op_e         op;

  assign op        = op_e'(cmd_op);
  assign folded    = hash ^ {24'b0, cmd_data};
  assign mul_sum   = hash + (xr << shift_of(step));
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rd_data   = digest[{rd_idx, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      step         <= '0;
      hash         <= FNV_OFFSET_BASIS;
      xr           <= '0;
      digest       <= '0;
      digest_valid <= 1'b0;
      byte_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            case (op)
              OP_BYTE: begin
                hash  <= folded;
                xr    <= folded;
                step  <= '0;
                state <= MUL;
                if (byte_count != '1) byte_count <= byte_count + 1'b1;
              end
              OP_INIT: begin
                hash         <= FNV_OFFSET_BASIS;
                byte_count   <= '0;
                digest_valid <= 1'b0;
              end
              OP_LATCH: begin
                digest       <= hash;
                digest_valid <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          hash <= mul_sum;
          if (step == 3'(MUL_STEPS - 1)) begin
            step  <= '0;
            state <= IDLE;
          end else begin
            step <= step + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fnv1a_hash_ctrl.sv
// Directed bench for fnv1a_hash_ctrl with hand-computed digests and a multiply-based model.
module tb_fnv1a_hash_ctrl;
  import fnv1a_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_data = 8'h00;
  logic [1:0]  rd_idx = 2'b00;
  logic        cmd_ready, busy, digest_valid;
  logic [7:0]  rd_data;
  logic [15:0] byte_count;
  logic        s_cmd_ready, s_busy, s_digest_valid;
  logic [7:0]  s_rd_data;
  logic [1:0]  s_byte_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fnv1a_hash_ctrl #(.COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rd_idx(rd_idx), .rd_data(rd_data),
    .digest_valid(digest_valid), .busy(busy), .byte_count(byte_count)
  );

  fnv1a_hash_ctrl #(.COUNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rd_idx(rd_idx), .rd_data(s_rd_data),
    .digest_valid(s_digest_valid), .busy(s_busy), .byte_count(s_byte_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] model_byte(input logic [31:0] h, input logic [7:0] b);
    return (h ^ {24'b0, b}) * FNV_PRIME;
  endfunction

  // Present a command, wait (bounded) for acceptance; returns cycles spent waiting for ready.
  task automatic send(input logic [1:0] op, input logic [7:0] d, output int waited);
    waited = 0;
    cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
    while (!cmd_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!cmd_ready) check("accept_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic read_digest(output logic [31:0] d, output logic [31:0] ds);
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i); #1;
      d[8*i +: 8]  = rd_data;
      ds[8*i +: 8] = s_rd_data;
    end
    rd_idx = 2'b00;
  endtask

  initial begin
    int w, lows;
    int acc_cyc[7];
    logic [31:0] d, ds, ref_h;
    logic [7:0] foobar [6];
    foobar = '{8'h66, 8'h6F, 8'h6F, 8'h62, 8'h61, 8'h72};

    // Reset state
    #12;
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dvalid", 32'(digest_valid), 32'd0);
    check("rst_count", 32'(byte_count), 32'd0);
    read_digest(d, ds);
    check("rst_digest", d, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Empty-string digest and per-byte read-back
    send(2'(OP_LATCH), 8'h00, w);
    check("empty_wait", 32'(w), 32'd0);
    check("empty_dvalid", 32'(digest_valid), 32'd1);
    check("empty_count", 32'(byte_count), 32'd0);
    rd_idx = 2'd0; #1; check("empty_rd0", 32'(rd_data), 32'hC5);
    rd_idx = 2'd1; #1; check("empty_rd1", 32'(rd_data), 32'h9D);
    rd_idx = 2'd2; #1; check("empty_rd2", 32'(rd_data), 32'h1C);
    rd_idx = 2'd3; #1; check("empty_rd3", 32'(rd_data), 32'h81);

    // "a": busy window of exactly 5 cycles after accept
    send(2'(OP_INIT), 8'h00, w);
    check("init_b2b_ready", 32'(cmd_ready), 32'd1);
    send(2'(OP_BYTE), 8'h61, w);
    lows = 0;
    while (!cmd_ready && lows < 20) begin
      check("a_busy_eq", 32'(busy), 32'd1);
      lows++;
      @(posedge clk); #1;
    end
    check("a_busy_cycles", 32'(lows), 32'd5);
    check("a_count", 32'(byte_count), 32'd1);
    send(2'(OP_LATCH), 8'h00, w);
    read_digest(d, ds);
    check("a_digest", d, 32'hE40C292C);

    // "foobar" with cmd_valid held high throughout
    send(2'(OP_INIT), 8'h00, w);
    cmd_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      logic pre;
      int guard;
      cmd_op   = (k < 6) ? 2'(OP_BYTE) : 2'(OP_LATCH);
      cmd_data = (k < 6) ? foobar[k] : 8'h00;
      guard = 0;
      do begin
        pre = cmd_ready;
        @(posedge clk); #1;
        guard++;
      end while (!pre && guard < 50);
      if (!pre) check("foobar_timeout", 32'(pre), 32'd1);
      acc_cyc[k] = cyc;
    end
    cmd_valid = 1'b0;
    for (int k = 1; k < 7; k++) check("foobar_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd6);
    read_digest(d, ds);
    check("foobar_digest", d, 32'hBF9CF968);
    check("foobar_count", 32'(byte_count), 32'd6);

    // Reset during MUL step 2
    send(2'(OP_BYTE), 8'h61, w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0; #2;
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_dvalid", 32'(digest_valid), 32'd0);
    check("mid_rst_count", 32'(byte_count), 32'd0);
    read_digest(d, ds);
    check("mid_rst_digest", d, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    send(2'(OP_LATCH), 8'h00, w);
    read_digest(d, ds);
    check("mid_rst_hash", d, FNV_OFFSET_BASIS);
    send(2'(OP_BYTE), 8'h61, w);
    send(2'(OP_LATCH), 8'h00, w);
    check("latch_after_byte_wait", 32'(w), 32'd5);
    read_digest(d, ds);
    check("mid_rst_a_digest", d, 32'hE40C292C);

    // INIT keeps digest; reserved opcode is a no-op with a 1-cycle handshake
    send(2'(OP_INIT), 8'h00, w);
    check("init_dvalid", 32'(digest_valid), 32'd0);
    read_digest(d, ds);
    check("init_digest_kept", d, 32'hE40C292C);
    send(2'(OP_RSVD), 8'h5A, w);
    check("rsvd_wait", 32'(w), 32'd0);
    check("rsvd_ready", 32'(cmd_ready), 32'd1);
    check("rsvd_dvalid", 32'(digest_valid), 32'd0);
    check("rsvd_count", 32'(byte_count), 32'd0);
    read_digest(d, ds);
    check("rsvd_digest", d, 32'hE40C292C);
    send(2'(OP_LATCH), 8'h00, w);
    read_digest(d, ds);
    check("rsvd_hash", d, FNV_OFFSET_BASIS);

    // Saturation: 5 bytes into both the 16-bit and 2-bit counter instances
    send(2'(OP_INIT), 8'h00, w);
    ref_h = FNV_OFFSET_BASIS;
    for (int k = 1; k <= 5; k++) begin
      send(2'(OP_BYTE), 8'(k * 8'h13), w);
      ref_h = model_byte(ref_h, 8'(k * 8'h13));
    end
    wait_idle: for (int k = 0; k < 10 && !cmd_ready; k++) begin
      @(posedge clk); #1;
    end
    check("sat_count", 32'(s_byte_count), 32'd3);
    check("wide_count", 32'(byte_count), 32'd5);
    send(2'(OP_LATCH), 8'h00, w);
    read_digest(d, ds);
    check("sat_digest", ds, ref_h);
    check("wide_digest", d, ref_h);
    check("sat_dvalid", 32'(s_digest_valid), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
